div_seq: RTL and testbench
==========================

DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 The block SHALL have parameter MAX_WAIT, default 64, giving the maximum number of WAIT cycles before abort.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  execute stage holds a DIV/DIVU; held high until stall drops.
REQ-005 sign  input  1  1 = signed DIV, 0 = DIVU; sampled with start.
REQ-006 flush  input  1  exception/pipeline cancel; kills any in-flight divide.
REQ-007 op_a  input  32  dividend; op_b  input  32  divisor.
REQ-008 ip_s_valid  output  1  operand-valid request to the divider IP.
REQ-009 ip_s_ready  input  1  divider IP accepts operands.
REQ-010 ip_sign  output  1  latched sign to the IP; ip_a, ip_b  output  32 each  latched operands.
REQ-011 ip_m_valid  input  1  IP result valid, one-cycle pulse.
REQ-012 ip_result  input  64  IP result: {quotient[63:32], remainder[31:0]}.
REQ-013 stall  output  1  freezes the pipeline while a live divide is pending.
REQ-014 hilo_we  output  2  HILO write enables {hi, lo}.
REQ-015 hilo_wdata  output  64  HILO write data: {HI = remainder, LO = quotient}.
REQ-016 busy  output  1  FSM not in IDLE.
REQ-017 err  output  1  one-cycle pulse on timeout abort.

Function
REQ-018 The FSM SHALL have the states IDLE, SEND, WAIT and DRAIN.
REQ-019 In IDLE, start=1 with flush=0 and op_b!=0 SHALL latch sign, op_a and op_b, and the next state SHALL be SEND.
REQ-020 stall SHALL equal start & !flush in IDLE; 1 in SEND and WAIT unless killed; 0 in the commit cycle; and start in DRAIN.
REQ-021 In IDLE, start=1 with op_b==0 SHALL make no IP request, keep stall at 0, and in the same cycle drive hilo_we=2'b11 and hilo_wdata={op_a, 32'hFFFF_FFFF}.
REQ-022 In SEND, ip_s_valid SHALL be 1 and operands SHALL be stable until ip_s_ready=1; on that handshake the next state SHALL be WAIT.
REQ-023 ip_s_valid SHALL never drop in SEND before the handshake, even on flush.
REQ-024 In WAIT, ip_m_valid=1 SHALL, in that same cycle, drive hilo_we=2'b11, hilo_wdata={ip_result[31:0], ip_result[63:32]} and stall=0, and the next state SHALL be IDLE.
REQ-025 The HILO write SHALL be exactly one cycle per divide, with one divide outstanding at most.
REQ-026 hilo_we SHALL be 2'b00 and hilo_wdata SHALL be 0 outside commit cycles.
REQ-027 flush=1 in SEND or WAIT SHALL set a kill flag: stall SHALL drop from the next cycle and the result SHALL be discarded (hilo_we stays 0).
REQ-028 A killed divide SHALL finish the SEND handshake and then go to DRAIN, or to DRAIN directly if already in WAIT.
REQ-029 DRAIN SHALL wait for ip_m_valid, discard the result, then go to IDLE.
REQ-030 A start arriving during DRAIN SHALL stall and be accepted in IDLE on the following cycle.
REQ-031 flush with start in the same IDLE cycle SHALL ignore start.
REQ-032 A wait counter SHALL clear on entry to WAIT or DRAIN, increment each cycle there, and saturate.
REQ-033 When the wait counter reaches MAX_WAIT without ip_m_valid, the block SHALL pulse err, drop stall, and go to IDLE with no HILO write.
REQ-034 ip_m_valid arriving in IDLE or SEND SHALL be ignored.

Reset
REQ-035 While rst=1, the state SHALL be IDLE; kill flag, counter, latched operands and every output SHALL be 0; reset SHALL take effect asynchronously.
REQ-036 Reset mid-divide SHALL abandon the operation with no HILO write; a late ip_m_valid after reset SHALL be ignored per REQ-034.

Verification
REQ-037 DIVU 100/7, IP ready immediately, result after 5 cycles -> stall high for 7 cycles, one hilo_we=11 with wdata={32'd2, 32'd14}.
REQ-038 DIV -7/2 with ip_s_ready delayed 3 cycles -> ip_s_valid held steady for 3 cycles, operands constant, commit {HI=-1, LO=-3}.
REQ-039 DIVU with op_b=0, op_a=5 -> no ip_s_valid; hilo_we=11 in the same cycle with {5, FFFFFFFF}; stall stays 0.
REQ-040 flush 2 cycles into WAIT, then new start -> stall drops, DRAIN until ip_m_valid, no HILO write, new divide issues the cycle after IDLE.
REQ-041 ip_m_valid never asserted, MAX_WAIT=8 -> err pulses after 8 WAIT cycles, state IDLE, stall 0, no write.
REQ-042 rst pulsed in WAIT, then stray ip_m_valid -> all outputs 0 immediately, busy 0, no HILO write.

Source files
------------

// File: rtl/div_seq.sv
// Sequential DIV/DIVU controller: hands latched operands to an external divider IP,
// holds the pipeline until the quotient/remainder commits to HI/LO, and discards flushed or timed-out divides.
module div_seq #(
  parameter int MAX_WAIT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sign,
  input  logic        flush,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        ip_s_valid,
  input  logic        ip_s_ready,
  output logic        ip_sign,
  output logic [31:0] ip_a,
  output logic [31:0] ip_b,
  input  logic        ip_m_valid,
  input  logic [63:0] ip_result,
  output logic        stall,
  output logic [1:0]  hilo_we,
  output logic [63:0] hilo_wdata,
  output logic        busy,
  output logic        err
);

  localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          kill;
  logic          kill_nxt;
  logic [CW-1:0] wait_cnt;
  logic          timeout;
  logic          latch_en;
  logic          in_wait_or_drain;
  logic          enter_wait_or_drain;

  assign timeout             = (wait_cnt == CNT_MAX);
  assign in_wait_or_drain    = (state == WAIT) || (state == DRAIN);
  assign enter_wait_or_drain = ((state_nxt == WAIT) || (state_nxt == DRAIN)) && (state_nxt != state);

  assign ip_s_valid = (state == SEND);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      kill  <= 1'b0;
    end else begin
      state <= state_nxt;
      kill  <= kill_nxt;
    end
  end

  // Operands only move in IDLE, so they stay put for the whole SEND handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ip_sign <= 1'b0;
      ip_a    <= '0;
      ip_b    <= '0;
    end else if (latch_en) begin
      ip_sign <= sign;
      ip_a    <= op_a;
      ip_b    <= op_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (enter_wait_or_drain) begin
      wait_cnt <= '0;
    end else if (in_wait_or_drain && !timeout) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end

  always_comb begin
    state_nxt  = state;
    kill_nxt   = kill;
    latch_en   = 1'b0;
    stall      = 1'b0;
    hilo_we    = 2'b00;
    hilo_wdata = '0;
    err        = 1'b0;

    unique case (state)
      IDLE: begin
        kill_nxt = 1'b0;
        if (start && !flush) begin
          if (op_b == '0) begin
            // Divide by zero never reaches the IP: HI keeps the dividend, LO saturates.
            hilo_we    = 2'b11;
            hilo_wdata = {op_a, 32'hFFFF_FFFF};
          end else begin
            stall     = 1'b1;
            latch_en  = 1'b1;
            state_nxt = SEND;
          end
        end
      end

      SEND: begin
        // A flush cannot retract ip_s_valid; it is remembered and the result drained later.
        stall    = !kill;
        kill_nxt = kill || flush;
        if (ip_s_ready) begin
          state_nxt = (kill || flush) ? DRAIN : WAIT;
        end
      end

      WAIT: begin
        stall    = !kill;
        kill_nxt = kill || flush;
        if (ip_m_valid) begin
          if (!kill && !flush) begin
            hilo_we    = 2'b11;
            hilo_wdata = {ip_result[31:0], ip_result[63:32]};
          end
          stall     = 1'b0;
          state_nxt = IDLE;
        end else if (timeout) begin
          err       = 1'b1;
          stall     = 1'b0;
          state_nxt = IDLE;
        end else if (flush) begin
          state_nxt = DRAIN;
        end
      end

      DRAIN: begin
        stall = start;
        if (ip_m_valid) begin
          state_nxt = IDLE;
        end else if (timeout) begin
          err       = 1'b1;
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
        kill_nxt  = 1'b0;
      end
    endcase

    // The IDLE decode looks straight at the inputs, so reset must mask it too.
    if (rst) begin
      latch_en   = 1'b0;
      stall      = 1'b0;
      hilo_we    = 2'b00;
      hilo_wdata = '0;
      err        = 1'b0;
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: normal divides, handshake stall, divide by zero, flush, timeout, async reset.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sign;
  logic        flush;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        ip_s_valid;
  logic        ip_s_ready;
  logic        ip_sign;
  logic [31:0] ip_a;
  logic [31:0] ip_b;
  logic        ip_m_valid;
  logic [63:0] ip_result;
  logic        stall;
  logic [1:0]  hilo_we;
  logic [63:0] hilo_wdata;
  logic        busy;
  logic        err;

  int vectors     = 0;
  int miscompares = 0;

  // {stall, busy, ip_s_valid, hilo_we, err}
  logic [5:0] ctl;
  assign ctl = {stall, busy, ip_s_valid, hilo_we, err};

  div_seq #(.MAX_WAIT(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .sign       (sign),
    .flush      (flush),
    .op_a       (op_a),
    .op_b       (op_b),
    .ip_s_valid (ip_s_valid),
    .ip_s_ready (ip_s_ready),
    .ip_sign    (ip_sign),
    .ip_a       (ip_a),
    .ip_b       (ip_b),
    .ip_m_valid (ip_m_valid),
    .ip_result  (ip_result),
    .stall      (stall),
    .hilo_we    (hilo_we),
    .hilo_wdata (hilo_wdata),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; sign = 1'b0; flush = 1'b0; op_a = 32'd5; op_b = 32'd0;
    ip_s_ready = 1'b0; ip_m_valid = 1'b1; ip_result = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    if (ctl !== 6'b000000) begin miscompares++; $display("FAIL reset_ctl: got %b want %b", ctl, 6'b000000); end
    vectors++;
    if ({ip_sign, ip_a, ip_b, hilo_wdata} !== '0) begin
      miscompares++; $display("FAIL reset_data: got %h/%h/%h/%h want all zero", ip_sign, ip_a, ip_b, hilo_wdata);
    end
    vectors++;
    rst = 1'b0; start = 1'b0; ip_m_valid = 1'b0; ip_result = '0; op_a = '0;
    step();
  endtask

  task automatic test_divu();
    int stall_hi;
    stall_hi = 0;
    sign = 1'b0; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
    @(negedge clk); stall_hi += int'(stall);
    if (ctl !== 6'b100000) begin miscompares++; $display("FAIL divu_idle: got %b want %b", ctl, 6'b100000); end
    vectors++;
    step();
    ip_s_ready = 1'b1;
    @(negedge clk); stall_hi += int'(stall);
    if (ctl !== 6'b111000) begin miscompares++; $display("FAIL divu_send: got %b want %b", ctl, 6'b111000); end
    vectors++;
    if ({ip_sign, ip_a, ip_b} !== {1'b0, 32'd100, 32'd7}) begin
      miscompares++; $display("FAIL divu_operands: got %b/%0d/%0d want 0/100/7", ip_sign, ip_a, ip_b);
    end
    vectors++;
    step();
    ip_s_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); stall_hi += int'(stall);
      if (ctl !== 6'b110000) begin miscompares++; $display("FAIL divu_wait%0d: got %b want %b", i, ctl, 6'b110000); end
      vectors++;
      step();
    end
    ip_m_valid = 1'b1; ip_result = {32'd14, 32'd2};
    @(negedge clk); stall_hi += int'(stall);
    if (ctl !== 6'b010110) begin miscompares++; $display("FAIL divu_commit: got %b want %b", ctl, 6'b010110); end
    vectors++;
    if (hilo_wdata !== {32'd2, 32'd14}) begin
      miscompares++; $display("FAIL divu_wdata: got %h want %h", hilo_wdata, {32'd2, 32'd14});
    end
    vectors++;
    step();
    ip_m_valid = 1'b0; ip_result = '0; start = 1'b0;
    @(negedge clk);
    if (ctl !== 6'b000000 || hilo_wdata !== 64'd0) begin
      miscompares++; $display("FAIL divu_after: got %b/%h want 000000/0", ctl, hilo_wdata);
    end
    vectors++;
    if (stall_hi !== 7) begin miscompares++; $display("FAIL divu_stall_cycles: got %0d want 7", stall_hi); end
    vectors++;
    step();
  endtask

  task automatic test_div_delayed();
    sign = 1'b1; op_a = 32'hFFFF_FFF9; op_b = 32'd2; start = 1'b1;
    @(negedge clk);
    if (ctl !== 6'b100000) begin miscompares++; $display("FAIL div_idle: got %b want %b", ctl, 6'b100000); end
    vectors++;
    step();
    for (int i = 0; i < 3; i++) begin
      ip_s_ready = 1'b0; sign = 1'b0; op_a = 32'hDEAD_0000 + i; op_b = 32'h1234;
      @(negedge clk);
      if (ctl !== 6'b111000) begin miscompares++; $display("FAIL div_hold%0d: got %b want %b", i, ctl, 6'b111000); end
      vectors++;
      if ({ip_sign, ip_a, ip_b} !== {1'b1, 32'hFFFF_FFF9, 32'd2}) begin
        miscompares++; $display("FAIL div_stable%0d: got %b/%h/%h want 1/fffffff9/2", i, ip_sign, ip_a, ip_b);
      end
      vectors++;
      step();
    end
    ip_s_ready = 1'b1;
    @(negedge clk);
    if (ctl !== 6'b111000) begin miscompares++; $display("FAIL div_handshake: got %b want %b", ctl, 6'b111000); end
    vectors++;
    step();
    ip_s_ready = 1'b0; ip_m_valid = 1'b1; ip_result = {32'hFFFF_FFFD, 32'hFFFF_FFFF};
    @(negedge clk);
    if (ctl !== 6'b010110) begin miscompares++; $display("FAIL div_commit: got %b want %b", ctl, 6'b010110); end
    vectors++;
    if (hilo_wdata !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
      miscompares++; $display("FAIL div_wdata: got %h want ffffffff_fffffffd", hilo_wdata);
    end
    vectors++;
    step();
    ip_m_valid = 1'b0; ip_result = '0; start = 1'b0;
  endtask

  task automatic test_div_zero();
    sign = 1'b0; op_a = 32'd5; op_b = 32'd0; start = 1'b1;
    @(negedge clk);
    if (ctl !== 6'b000110) begin miscompares++; $display("FAIL dz_ctl: got %b want %b", ctl, 6'b000110); end
    vectors++;
    if (hilo_wdata !== {32'd5, 32'hFFFF_FFFF}) begin
      miscompares++; $display("FAIL dz_wdata: got %h want 00000005_ffffffff", hilo_wdata);
    end
    vectors++;
    step();
    start = 1'b0; ip_m_valid = 1'b1; ip_result = 64'h1;
    @(negedge clk);
    if (ctl !== 6'b000000 || hilo_wdata !== 64'd0) begin
      miscompares++; $display("FAIL dz_stray_mvalid: got %b/%h want 000000/0", ctl, hilo_wdata);
    end
    vectors++;
    step();
    ip_m_valid = 1'b0; ip_result = '0;
  endtask

  task automatic test_flush_send();
    op_a = 32'd50; op_b = 32'd5; start = 1'b1;
    @(negedge clk);
    if (ctl !== 6'b100000) begin miscompares++; $display("FAIL fs_idle: got %b want %b", ctl, 6'b100000); end
    vectors++;
    step();
    flush = 1'b1; ip_s_ready = 1'b0;
    @(negedge clk);
    if (ctl !== 6'b111000) begin miscompares++; $display("FAIL fs_flush_cycle: got %b want %b", ctl, 6'b111000); end
    vectors++;
    step();
    flush = 1'b0; start = 1'b0;
    @(negedge clk);
    if (ctl !== 6'b011000) begin miscompares++; $display("FAIL fs_killed_send: got %b want %b", ctl, 6'b011000); end
    vectors++;
    step();
    ip_s_ready = 1'b1;
    @(negedge clk);
    if (ctl !== 6'b011000) begin miscompares++; $display("FAIL fs_handshake: got %b want %b", ctl, 6'b011000); end
    vectors++;
    step();
    ip_s_ready = 1'b0;
    @(negedge clk);
    if (ctl !== 6'b010000) begin miscompares++; $display("FAIL fs_drain: got %b want %b", ctl, 6'b010000); end
    vectors++;
    step();
    ip_m_valid = 1'b1; ip_result = 64'hA;
    @(negedge clk);
    if (ctl !== 6'b010000 || hilo_wdata !== 64'd0) begin
      miscompares++; $display("FAIL fs_discard: got %b/%h want 010000/0", ctl, hilo_wdata);
    end
    vectors++;
    step();
    ip_m_valid = 1'b0; ip_result = '0;
    @(negedge clk);
    if (ctl !== 6'b000000) begin miscompares++; $display("FAIL fs_idle_after: got %b want %b", ctl, 6'b000000); end
    vectors++;
    step();
  endtask

  task automatic test_flush_drain();
    op_a = 32'd9; op_b = 32'd3; start = 1'b1;
    step();
    ip_s_ready = 1'b1;
    step();
    ip_s_ready = 1'b0;
    @(negedge clk);
    if (ctl !== 6'b110000) begin miscompares++; $display("FAIL fd_wait1: got %b want %b", ctl, 6'b110000); end
    vectors++;
    step();
    flush = 1'b1;
    @(negedge clk);
    if (ctl !== 6'b110000) begin miscompares++; $display("FAIL fd_flush_cycle: got %b want %b", ctl, 6'b110000); end
    vectors++;
    step();
    flush = 1'b0; start = 1'b0;
    @(negedge clk);
    if (ctl !== 6'b010000) begin miscompares++; $display("FAIL fd_drain: got %b want %b", ctl, 6'b010000); end
    vectors++;
    step();
    start = 1'b1; op_a = 32'd20; op_b = 32'd4;
    @(negedge clk);
    if (ctl !== 6'b110000) begin miscompares++; $display("FAIL fd_drain_start: got %b want %b", ctl, 6'b110000); end
    vectors++;
    step();
    ip_m_valid = 1'b1; ip_result = {32'd3, 32'd0};
    @(negedge clk);
    if (ctl !== 6'b110000 || hilo_wdata !== 64'd0) begin
      miscompares++; $display("FAIL fd_discard: got %b/%h want 110000/0", ctl, hilo_wdata);
    end
    vectors++;
    step();
    ip_m_valid = 1'b0; ip_result = '0;
    @(negedge clk);
    if (ctl !== 6'b100000) begin miscompares++; $display("FAIL fd_accept: got %b want %b", ctl, 6'b100000); end
    vectors++;
    step();
    ip_s_ready = 1'b1;
    @(negedge clk);
    if (ctl !== 6'b111000 || ip_a !== 32'd20 || ip_b !== 32'd4) begin
      miscompares++; $display("FAIL fd_reissue: got %b/%0d/%0d want 111000/20/4", ctl, ip_a, ip_b);
    end
    vectors++;
    step();
    ip_s_ready = 1'b0; ip_m_valid = 1'b1; ip_result = {32'd5, 32'd0};
    @(negedge clk);
    if (ctl !== 6'b010110 || hilo_wdata !== {32'd0, 32'd5}) begin
      miscompares++; $display("FAIL fd_commit: got %b/%h want 010110/00000000_00000005", ctl, hilo_wdata);
    end
    vectors++;
    step();
    ip_m_valid = 1'b0; ip_result = '0; start = 1'b0;
  endtask

  task automatic test_timeout();
    op_a = 32'd1; op_b = 32'd1; start = 1'b1;
    step();
    ip_s_ready = 1'b1;
    step();
    ip_s_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ctl !== 6'b110000) begin miscompares++; $display("FAIL to_wait%0d: got %b want %b", i, ctl, 6'b110000); end
      vectors++;
      step();
    end
    @(negedge clk);
    if (ctl !== 6'b010001) begin miscompares++; $display("FAIL to_err: got %b want %b", ctl, 6'b010001); end
    vectors++;
    step();
    start = 1'b0;
    @(negedge clk);
    if (ctl !== 6'b000000) begin miscompares++; $display("FAIL to_idle: got %b want %b", ctl, 6'b000000); end
    vectors++;
    step();
    ip_m_valid = 1'b1; ip_result = 64'h55;
    @(negedge clk);
    if (ctl !== 6'b000000) begin miscompares++; $display("FAIL to_late_mvalid: got %b want %b", ctl, 6'b000000); end
    vectors++;
    step();
    ip_m_valid = 1'b0; ip_result = '0;
  endtask

  task automatic test_reset_mid();
    op_a = 32'd30; op_b = 32'd6; start = 1'b1;
    step();
    ip_s_ready = 1'b1;
    step();
    ip_s_ready = 1'b0;
    @(negedge clk);
    if (ctl !== 6'b110000) begin miscompares++; $display("FAIL rm_wait: got %b want %b", ctl, 6'b110000); end
    vectors++;
    step();
    rst = 1'b1;
    #1;
    if (ctl !== 6'b000000 || {ip_sign, ip_a, ip_b, hilo_wdata} !== '0) begin
      miscompares++; $display("FAIL rm_async: got %b/%h/%h want 000000/0/0", ctl, ip_a, hilo_wdata);
    end
    vectors++;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    step();
    ip_m_valid = 1'b1; ip_result = {32'd5, 32'd0};
    @(negedge clk);
    if (ctl !== 6'b000000 || hilo_wdata !== 64'd0) begin
      miscompares++; $display("FAIL rm_stray_mvalid: got %b/%h want 000000/0", ctl, hilo_wdata);
    end
    vectors++;
    step();
    ip_m_valid = 1'b0; ip_result = '0;
  endtask

  initial begin
    test_reset();
    test_divu();
    test_div_delayed();
    test_div_zero();
    test_flush_send();
    test_flush_drain();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
